// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// Optional checksum stage is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // Word index must be able to hold the full count MEM_WORDS.
    function automatic int idx_width(input int mem_words);
        return $clog2(mem_words + 1);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
// word_vld is combinational with the 4th byte; no backpressure, clear restarts.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (byte_vld) begin
            shreg    <= {shreg[15:0], byte_dat};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_vld = byte_vld && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word_dat = {shreg, byte_dat};

endmodule

// File: rtl/imem_loader.sv
// Downloads a count-prefixed byte stream into instruction memory, holding the CPU meanwhile.
// Write strobe one cycle after a word's 4th byte; input never stalls during a load.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [30:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int IW = idx_width(MEM_WORDS);

    loader_state_t state, state_nxt;
    logic [IW-1:0] word_idx;
    logic [IW-1:0] word_cnt;
    logic          xfer;
    logic          load_go;
    logic          count_ok;
    logic          last_word;
    logic          word_vld;
    logic [31:0]   word_dat;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    acc;
`endif

    assign xfer      = in_valid && in_ready;
    assign load_go   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign count_ok  = (in_data != 8'd0) && (int'(in_data) <= MEM_WORDS);
    assign last_word = (word_idx == word_cnt - IW'(1));

    word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_go),
        .byte_vld (xfer && state == ST_DATA),
        .byte_dat (in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cpu_hold  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            ST_COUNT: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (xfer)
                    state_nxt = count_ok ? ST_DATA : ST_ERR;
            end
            ST_DATA: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (word_vld && last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (xfer)
                    state_nxt = (in_data == acc) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: done = 1'b1;
            ST_ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
        if (load_go)
            state_nxt = ST_COUNT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            word_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= word_vld;
            if (load_go)
                word_idx <= '0;
            if (state == ST_COUNT && xfer && count_ok)
                word_cnt <= IW'(in_data);
            if (word_vld) begin
                wr_addr  <= 31'({word_idx, 2'b00});
                wr_data  <= word_dat;
                word_idx <= word_idx + IW'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Only data bytes feed the checksum; the count byte is excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (load_go)
            acc <= '0;
        else if (state == ST_DATA && xfer)
            acc <= acc ^ in_data;
    end
`endif

endmodule
